uart_deframer: RTL and testbench

- UART receive-side deframer, the counterpart of the transmit framer.
- Recovers start / data / parity / stop fields from the serial line using the oversampling tick, and checks parity and stop bits.
- Presents the received byte with error flags to the host-side receive logic.
- Uses the same frame configuration encoding as the transmit path: LSB-first data, start bit 0, idle/stop level 1.

---
 rtl/uart_deframer.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_deframer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_deframer.sv
// UART receive deframer: recovers start/data/parity/stop fields from an oversampled
// serial line and presents the byte with parity and framing error flags.
module uart_deframer #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx_in,
  input  logic [1:0] parity_type,
  input  logic       data_length,
  input  logic       stop_bits,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    DONE      = 3'd5,
    WAIT_HIGH = 3'd6
  } state_t;

  // Expected parity bit over 7 or 8 data bits; odd selects odd parity.
  function automatic logic calc_parity(input logic [7:0] d, input logic len8, input logic odd);
    logic x;
    x = len8 ? (^d) : (^d[6:0]);
    return odd ? ~x : x;
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rxs_s;

  state_t          state_r, state_nx;
  logic [CW-1:0]   cnt_r, cnt_nx;
  logic [2:0]      bit_r, bit_nx;
  logic [7:0]      shift_r, shift_nx;
  logic            perr_r, perr_nx;
  logic            ferr_r, ferr_nx;
  logic [1:0]      cfg_par_r, cfg_par_nx;
  logic            cfg_len_r, cfg_len_nx;
  logic            cfg_stop_r, cfg_stop_nx;

  logic [7:0]      data_out_r, data_out_nx;
  logic            data_valid_r, data_valid_nx;
  logic            parity_error_r, parity_error_nx;
  logic            framing_error_r, framing_error_nx;
  logic            busy_r;

  logic            par_en_s;
  logic [2:0]      last_bit_s;

  assign rxs_s      = sync_r[SYNC_STAGES-1];
  assign par_en_s   = (cfg_par_r == 2'b01) || (cfg_par_r == 2'b10);
  assign last_bit_s = cfg_len_r ? 3'd7 : 3'd6;

  // rx_in metastability synchronizer, idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx_in};
    end
  end

  // Next-state, counters, sampling and output-register updates
  always_comb begin
    state_nx         = state_r;
    cnt_nx           = cnt_r;
    bit_nx           = bit_r;
    shift_nx         = shift_r;
    perr_nx          = perr_r;
    ferr_nx          = ferr_r;
    cfg_par_nx       = cfg_par_r;
    cfg_len_nx       = cfg_len_r;
    cfg_stop_nx      = cfg_stop_r;
    data_out_nx      = data_out_r;
    data_valid_nx    = 1'b0;
    parity_error_nx  = parity_error_r;
    framing_error_nx = framing_error_r;

    case (state_r)
      IDLE: begin
        if (baud_tick && !rxs_s) begin
          state_nx    = START;
          cnt_nx      = CNT_ZERO;
          bit_nx      = 3'd0;
          shift_nx    = 8'h00;
          perr_nx     = 1'b0;
          ferr_nx     = 1'b0;
          cfg_par_nx  = parity_type;
          cfg_len_nx  = data_length;
          cfg_stop_nx = stop_bits;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (baud_tick) begin
          if (cnt_r == CNT_MID) begin
            cnt_nx   = CNT_ZERO;
            state_nx = rxs_s ? IDLE : DATA;
          end else begin
            cnt_nx = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nx = cnt_r;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (cnt_r == CNT_LAST) begin
            cnt_nx          = CNT_ZERO;
            shift_nx[bit_r] = rxs_s;
            if (bit_r == last_bit_s) begin
              bit_nx   = 3'd0;
              state_nx = par_en_s ? PARITY : STOP;
            end else begin
              bit_nx = bit_r + 3'd1;
            end
          end else begin
            cnt_nx = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nx = cnt_r;
        end
      end
      PARITY: begin
        if (baud_tick) begin
          if (cnt_r == CNT_LAST) begin
            cnt_nx   = CNT_ZERO;
            perr_nx  = rxs_s != calc_parity(shift_r, cfg_len_r, cfg_par_r == 2'b01);
            state_nx = STOP;
          end else begin
            cnt_nx = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nx = cnt_r;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (cnt_r == CNT_LAST) begin
            cnt_nx  = CNT_ZERO;
            ferr_nx = ferr_r | ~rxs_s;
            if (bit_r == {2'b00, cfg_stop_r}) begin
              bit_nx   = 3'd0;
              state_nx = DONE;
            end else begin
              bit_nx = bit_r + 3'd1;
            end
          end else begin
            cnt_nx = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nx = cnt_r;
        end
      end
      DONE: begin
        data_valid_nx    = 1'b1;
        data_out_nx      = cfg_len_r ? shift_r : {1'b0, shift_r[6:0]};
        parity_error_nx  = perr_r;
        framing_error_nx = ferr_r;
        state_nx         = ferr_r ? WAIT_HIGH : IDLE;
      end
      WAIT_HIGH: begin
        // Line held low after a bad stop bit: wait for it to recover before rearming
        if (baud_tick && rxs_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = WAIT_HIGH;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // FSM, counter, shift register and latched configuration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      bit_r      <= 3'd0;
      shift_r    <= 8'h00;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      cfg_par_r  <= 2'b00;
      cfg_len_r  <= 1'b0;
      cfg_stop_r <= 1'b0;
    end else begin
      state_r    <= state_nx;
      cnt_r      <= cnt_nx;
      bit_r      <= bit_nx;
      shift_r    <= shift_nx;
      perr_r     <= perr_nx;
      ferr_r     <= ferr_nx;
      cfg_par_r  <= cfg_par_nx;
      cfg_len_r  <= cfg_len_nx;
      cfg_stop_r <= cfg_stop_nx;
    end
  end

  // Registered host-facing outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_r      <= 8'h00;
      data_valid_r    <= 1'b0;
      parity_error_r  <= 1'b0;
      framing_error_r <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      data_out_r      <= data_out_nx;
      data_valid_r    <= data_valid_nx;
      parity_error_r  <= parity_error_nx;
      framing_error_r <= framing_error_nx;
      busy_r          <= (state_nx != IDLE);
    end
  end

  assign data_out      = data_out_r;
  assign data_valid    = data_valid_r;
  assign parity_error  = parity_error_r;
  assign framing_error = framing_error_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_uart_deframer.sv
// Self-checking bench for uart_deframer: directed frames with a frame-level
// expectation queue checked on every cycle, plus hand-computed pins.
module tb_uart_deframer;
  localparam int OS     = 16;
  localparam int TDIV   = 4;
  localparam int BITCLK = OS * TDIV;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       rx_in;
  logic [1:0] parity_type;
  logic       data_length;
  logic       stop_bits;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  uart_deframer #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_in),
    .parity_type(parity_type), .data_length(data_length), .stop_bits(stop_bits),
    .data_out(data_out), .data_valid(data_valid), .parity_error(parity_error),
    .framing_error(framing_error), .busy(busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  exp_t last_e;
  int   ncheck = 0;
  int   nfail  = 0;
  int   nvalid = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // baud tick every TDIV clocks, driven just after the rising edge
  initial begin
    int t;
    t = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      t = (t + 1) % TDIV;
      baud_tick = (t == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every cycle: a pulse must match the next expected frame, otherwise outputs hold
  initial begin
    logic prev_dv;
    exp_t e;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        check("dv_one_clk", {31'd0, prev_dv}, 32'd0);
        ncheck++;
        if (q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_valid: got data_valid with data_out %0h, expected no frame", data_out);
        end else begin
          e = q.pop_front();
          check("frame_data", {24'd0, data_out}, {24'd0, e.d});
          check("frame_perr", {31'd0, parity_error}, {31'd0, e.pe});
          check("frame_ferr", {31'd0, framing_error}, {31'd0, e.fe});
          last_e = e;
          nvalid++;
        end
      end else begin
        check("hold_data", {24'd0, data_out}, {24'd0, last_e.d});
        check("hold_perr", {31'd0, parity_error}, {31'd0, last_e.pe});
        check("hold_ferr", {31'd0, framing_error}, {31'd0, last_e.fe});
      end
      prev_dv = data_valid;
    end
  end

  task automatic drive_bit(input logic b);
    #1 rx_in = b;
    repeat (BITCLK) @(posedge clk);
  endtask

  // Sends one frame with the current configuration and queues what the receiver must report
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_val);
    exp_t e;
    logic [7:0] dm;
    int nd;
    int ones;
    nd   = data_length ? 8 : 7;
    dm   = data_length ? d : {1'b0, d[6:0]};
    ones = $countones(dm) + (p ? 1 : 0);
    e.d  = dm;
    e.pe = (parity_type == 2'b01) ? ((ones % 2) == 0) :
           (parity_type == 2'b10) ? ((ones % 2) == 1) : 1'b0;
    e.fe = ~stop_val;
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < nd; i++) drive_bit(dm[i]);
    if (parity_type == 2'b01 || parity_type == 2'b10) drive_bit(p);
    drive_bit(stop_val);
    if (stop_bits) drive_bit(stop_val);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 4 * BITCLK) begin
      @(posedge clk);
      n++;
    end
    ncheck++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL %s: %0d frames still outstanding, expected 0", name, q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_not_busy(input string name, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic set_cfg(input logic [1:0] p, input logic len, input logic stp);
    parity_type = p;
    data_length = len;
    stop_bits   = stp;
  endtask

  initial begin
    last_e = '0;
    rx_in  = 1'b1;
    set_cfg(2'b00, 1'b1, 1'b0);
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_data", {24'd0, data_out}, 32'h0);
    check("rst_dv", {31'd0, data_valid}, 32'h0);
    check("rst_perr", {31'd0, parity_error}, 32'h0);
    check("rst_ferr", {31'd0, framing_error}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    rst = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);

    // 8N1 0xA5
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_drain("drain_8n1");
    check("pin_a5_data", {24'd0, data_out}, 32'hA5);
    check("pin_a5_perr", {31'd0, parity_error}, 32'h0);
    check("pin_a5_busy", {31'd0, busy}, 32'h0);
    check("pin_a5_count", nvalid, 32'd1);

    // 7E2 0x41, good then bad parity
    set_cfg(2'b10, 1'b0, 1'b1);
    drive_bit(1'b1);
    send_frame(8'h41, 1'b0, 1'b1);
    wait_drain("drain_7e2_ok");
    check("pin_7e2_data", {24'd0, data_out}, 32'h41);
    check("pin_7e2_perr", {31'd0, parity_error}, 32'h0);
    send_frame(8'h41, 1'b1, 1'b1);
    wait_drain("drain_7e2_bad");
    check("pin_7e2b_data", {24'd0, data_out}, 32'h41);
    check("pin_7e2b_perr", {31'd0, parity_error}, 32'h1);

    // 8O1 0x00 with a low stop bit and the line stuck low afterwards
    set_cfg(2'b01, 1'b1, 1'b0);
    drive_bit(1'b1);
    send_frame(8'h00, 1'b1, 1'b0);
    wait_drain("drain_8o1_ferr");
    check("pin_ferr", {31'd0, framing_error}, 32'h1);
    check("pin_ferr_perr", {31'd0, parity_error}, 32'h0);
    check("pin_ferr_busy", {31'd0, busy}, 32'h1);
    repeat (2 * BITCLK) @(posedge clk);
    #1;
    check("wait_high_busy", {31'd0, busy}, 32'h1);
    rx_in = 1'b1;
    wait_not_busy("wait_high_release", 10 * TDIV);
    drive_bit(1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_drain("drain_8o1_ok");
    check("pin_3c_data", {24'd0, data_out}, 32'h3C);
    check("pin_3c_ferr", {31'd0, framing_error}, 32'h0);

    // glitch: low for 4 ticks only
    drive_bit(1'b1);
    #1 rx_in = 1'b0;
    repeat (4 * TDIV) @(posedge clk);
    #1;
    check("glitch_busy", {31'd0, busy}, 32'h1);
    rx_in = 1'b1;
    wait_not_busy("glitch_release", 12 * TDIV);
    repeat (BITCLK) @(posedge clk);
    #1;
    check("glitch_data", {24'd0, data_out}, 32'h3C);
    check("glitch_count", nvalid, 32'd5);

    // back-to-back 8N1 frames
    set_cfg(2'b00, 1'b1, 1'b0);
    drive_bit(1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    wait_drain("drain_b2b");
    check("pin_b2b_data", {24'd0, data_out}, 32'hAA);
    check("pin_b2b_count", nvalid, 32'd7);

    // reset halfway through the data bits of 0xFF
    drive_bit(1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (BITCLK / 2) @(posedge clk);
    #1;
    q.delete();
    last_e = '0;
    rst = 1'b0;
    #1;
    check("abort_data", {24'd0, data_out}, 32'h0);
    check("abort_dv", {31'd0, data_valid}, 32'h0);
    check("abort_busy", {31'd0, busy}, 32'h0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h12, 1'b0, 1'b1);
    wait_drain("drain_after_rst");
    check("pin_12_data", {24'd0, data_out}, 32'h12);
    check("pin_12_flags", {30'd0, parity_error, framing_error}, 32'h0);
    check("pin_12_count", nvalid, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end
endmodule
